// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU definitions for the register-file write arbiter: register/data
// widths, the zero register and the arbiter state encoding.
package rf_write_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  // Register 0 is hardwired; only nonzero destinations are real writes.
  function automatic logic is_write_reg(input logic [REG_W-1:0] r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundles the WB, MDU, decode and register-file write signals around the
// arbiter. The master side is the pipeline/MDU/RF environment, the slave
// side is the arbiter itself.
interface rf_write_arbiter_if;
  import rf_write_arbiter_pkg::*;

  logic              wb_valid;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              mdu_valid;
  logic [REG_W-1:0]  mdu_reg;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic [REG_W-1:0]  rs_addr;
  logic [REG_W-1:0]  rt_addr;
  logic              rs_pending;
  logic              rt_pending;
  logic              pipe_stall;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output wb_valid, wb_reg, wb_data,
    output mdu_valid, mdu_reg, mdu_data,
    output rs_addr, rt_addr,
    input  mdu_ready, rs_pending, rt_pending, pipe_stall,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  mdu_valid, mdu_reg, mdu_data,
    input  rs_addr, rt_addr,
    output mdu_ready, rs_pending, rt_pending, pipe_stall,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_write_arbiter_buffer.sv
// One-entry holding register for an MDU result waiting for a write slot,
// with source-register match outputs used for decode interlocks.
module rf_wr_buffer
  import rf_write_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              kill,
  input  logic              drain,
  input  logic [REG_W-1:0]  ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_W-1:0]  rs_addr,
  input  logic [REG_W-1:0]  rt_addr,
  output logic              buf_valid,
  output logic [REG_W-1:0]  buf_reg,
  output logic [DATA_W-1:0] buf_data,
  output logic              rs_match,
  output logic              rt_match
);

  // Load wins over kill/drain so a slot freed this cycle can be refilled at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_reg   <= REG_ZERO;
      buf_data  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_reg   <= ld_reg;
      buf_data  <= ld_data;
    end else if (kill || drain) begin
      buf_valid <= 1'b0;
    end
  end

  assign rs_match = buf_valid && (rs_addr == buf_reg) && is_write_reg(rs_addr);
  assign rt_match = buf_valid && (rt_addr == buf_reg) && is_write_reg(rt_addr);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between the WB stage and
// the MDU result path. One MDU result can be parked; it takes idle slots and,
// if WB keeps the port busy for STARVE_LIMIT cycles, a one-cycle stall forces
// it through.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  arb_state_e        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              starve_hit;

  logic              wb_req;
  logic              mdu_take;
  logic              load;
  logic              kill;
  logic              drain;

  logic              buf_valid;
  logic [REG_W-1:0]  buf_reg;
  logic [DATA_W-1:0] buf_data;
  logic              rs_match;
  logic              rt_match;

  logic              mdu_ready;
  logic              pipe_stall;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign wb_req     = bus.wb_valid && is_write_reg(bus.wb_reg);
  // A result for register 0 is still accepted but has nothing to write.
  assign mdu_take   = bus.mdu_valid && is_write_reg(bus.mdu_reg);
  assign cnt_inc    = starve_cnt + CNT_W'(1);
  assign starve_hit = (cnt_inc == CNT_W'(STARVE_LIMIT));

  rf_wr_buffer u_buffer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .kill      (kill),
    .drain     (drain),
    .ld_reg    (bus.mdu_reg),
    .ld_data   (bus.mdu_data),
    .rs_addr   (bus.rs_addr),
    .rt_addr   (bus.rt_addr),
    .buf_valid (buf_valid),
    .buf_reg   (buf_reg),
    .buf_data  (buf_data),
    .rs_match  (rs_match),
    .rt_match  (rt_match)
  );

  // Per-cycle grant decision and buffer controls from the current state and inputs.
  always_comb begin
    mdu_ready  = 1'b1;
    pipe_stall = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = REG_ZERO;
    rf_wdata   = '0;
    load       = 1'b0;
    kill       = 1'b0;
    drain      = 1'b0;
    case (state)
      IDLE: begin
        if (wb_req) begin
          rf_we    = 1'b1;
          rf_waddr = bus.wb_reg;
          rf_wdata = bus.wb_data;
          load     = mdu_take;
        end else if (mdu_take) begin
          // Free port: the MDU result goes straight through, never parked.
          rf_we    = 1'b1;
          rf_waddr = bus.mdu_reg;
          rf_wdata = bus.mdu_data;
        end
      end
      HELD: begin
        if (wb_req) begin
          rf_we     = 1'b1;
          rf_waddr  = bus.wb_reg;
          rf_wdata  = bus.wb_data;
          // The younger WB write to the same register makes the parked value dead.
          kill      = (bus.wb_reg == buf_reg);
          mdu_ready = kill;
          load      = kill && mdu_take;
        end else begin
          rf_we    = 1'b1;
          rf_waddr = buf_reg;
          rf_wdata = buf_data;
          drain    = 1'b1;
          load     = mdu_take;
        end
      end
      FORCE: begin
        // WB is frozen and will re-present its write next cycle.
        pipe_stall = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = buf_reg;
        rf_wdata   = buf_data;
        drain      = 1'b1;
        load       = mdu_take;
      end
      default: begin
        mdu_ready = 1'b1;
      end
    endcase
  end

  // State and starvation counter: count WB wins over a parked result, force it at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          starve_cnt <= '0;
          state      <= load ? HELD : IDLE;
        end
        HELD: begin
          if (wb_req && !kill) begin
            starve_cnt <= cnt_inc;
            state      <= starve_hit ? FORCE : HELD;
          end else begin
            starve_cnt <= '0;
            state      <= load ? HELD : IDLE;
          end
        end
        FORCE: begin
          starve_cnt <= '0;
          state      <= load ? HELD : IDLE;
        end
        default: begin
          starve_cnt <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.mdu_ready  = mdu_ready;
  assign bus.pipe_stall = pipe_stall;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.rs_pending = rs_match;
  assign bus.rt_pending = rt_match;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the write-port rules.
module tb_rf_write_arbiter;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: at most one parked result plus how many cycles WB has beaten it.
  bit          m_have, n_have;
  logic [4:0]  m_reg, n_reg;
  logic [31:0] m_data, n_data;
  int          m_wait, n_wait;
  logic        exp_we, exp_ready, exp_stall, exp_rsp, exp_rtp;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  task automatic model_reset();
    m_have = 0; m_reg = '0; m_data = '0; m_wait = 0;
  endtask

  task automatic model_eval();
    bit wb_req, mdu_ok;
    wb_req = bus.wb_valid && (bus.wb_reg != 0);
    mdu_ok = bus.mdu_valid && (bus.mdu_reg != 0);
    exp_we = 0; exp_addr = '0; exp_data = '0; exp_ready = 1; exp_stall = 0;
    exp_rsp = m_have && (bus.rs_addr == m_reg) && (bus.rs_addr != 0);
    exp_rtp = m_have && (bus.rt_addr == m_reg) && (bus.rt_addr != 0);
    n_have = m_have; n_reg = m_reg; n_data = m_data; n_wait = m_wait;
    if (m_have && m_wait == LIMIT) begin
      exp_stall = 1; exp_we = 1; exp_addr = m_reg; exp_data = m_data;
      n_have = mdu_ok; n_wait = 0;
    end else if (m_have && wb_req) begin
      exp_we = 1; exp_addr = bus.wb_reg; exp_data = bus.wb_data;
      if (bus.wb_reg == m_reg) begin
        n_have = mdu_ok; n_wait = 0;
      end else begin
        exp_ready = 0; n_wait = m_wait + 1;
      end
    end else if (m_have) begin
      exp_we = 1; exp_addr = m_reg; exp_data = m_data;
      n_have = mdu_ok; n_wait = 0;
    end else if (wb_req) begin
      exp_we = 1; exp_addr = bus.wb_reg; exp_data = bus.wb_data;
      n_have = mdu_ok; n_wait = 0;
    end else if (mdu_ok) begin
      exp_we = 1; exp_addr = bus.mdu_reg; exp_data = bus.mdu_data;
    end
    if (exp_ready && mdu_ok && n_have) begin
      n_reg = bus.mdu_reg; n_data = bus.mdu_data;
    end
  endtask

  task automatic model_commit();
    m_have = n_have; m_reg = n_reg; m_data = n_data; m_wait = n_wait;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.wb_valid = wv; bus.wb_reg = wr; bus.wb_data = wd;
    bus.mdu_valid = mv; bus.mdu_reg = mr; bus.mdu_data = md;
    bus.rs_addr = rs; bus.rt_addr = rt;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 5, 5);
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", bus.mdu_ready); end
    checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", bus.pipe_stall); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", bus.rf_we); end
    checks++; if (bus.rs_pending !== 1'b0) begin errors++; $display("FAIL reset_rs_pending: got %0b expected 0", bus.rs_pending); end
    reset = 0;
    model_reset();
  endtask

  task automatic test_wb_basic();
    drive(1, 5, 32'h1234, 0, 0, 0, 0, 0);
    settle();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h1234)
      begin errors++; $display("FAIL wb_basic_write: got we=%0b addr=%0d data=%0h expected we=1 addr=5 data=1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.mdu_ready !== 1'b1 || bus.pipe_stall !== 1'b0)
      begin errors++; $display("FAIL wb_basic_ctrl: got ready=%0b stall=%0b expected ready=1 stall=0", bus.mdu_ready, bus.pipe_stall); end
    advance();
  endtask

  task automatic test_write_through();
    drive(0, 0, 0, 1, 8, 32'hDEAD, 8, 0);
    settle();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8 || bus.rf_wdata !== 32'hDEAD)
      begin errors++; $display("FAIL through_write: got we=%0b addr=%0d data=%0h expected we=1 addr=8 data=dead", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.rs_pending !== 1'b0) begin errors++; $display("FAIL through_pending: got %0b expected 0", bus.rs_pending); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 8, 8);
    settle();
    checks++; if (bus.rs_pending !== 1'b0 || bus.rf_we !== 1'b0)
      begin errors++; $display("FAIL through_not_buffered: got pend=%0b we=%0b expected 0 0", bus.rs_pending, bus.rf_we); end
    advance();
  endtask

  task automatic test_buffer_drain();
    drive(1, 3, 32'h1111, 1, 9, 32'hBEEF, 0, 0);
    settle();
    checks++; if (bus.rf_waddr !== 5'd3 || bus.mdu_ready !== 1'b1)
      begin errors++; $display("FAIL drain_load: got addr=%0d ready=%0b expected addr=3 ready=1", bus.rf_waddr, bus.mdu_ready); end
    advance();
    drive(1, 3, 32'h2222, 0, 0, 0, 0, 9);
    settle();
    checks++; if (bus.rt_pending !== 1'b1 || bus.mdu_ready !== 1'b0)
      begin errors++; $display("FAIL drain_held: got rt_pend=%0b ready=%0b expected 1 0", bus.rt_pending, bus.mdu_ready); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 9);
    settle();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'hBEEF)
      begin errors++; $display("FAIL drain_write: got we=%0b addr=%0d data=%0h expected 1 9 beef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    advance();
    settle();
    checks++; if (bus.rt_pending !== 1'b0 || bus.rf_we !== 1'b0)
      begin errors++; $display("FAIL drain_idle: got rt_pend=%0b we=%0b expected 0 0", bus.rt_pending, bus.rf_we); end
    advance();
  endtask

  task automatic test_starvation();
    drive(1, 4, 32'h44, 1, 10, 32'hAAAA, 10, 0);
    settle();
    advance();
    drive(1, 4, 32'h44, 0, 0, 0, 10, 0);
    for (int i = 0; i < LIMIT; i++) begin
      settle();
      checks++; if (bus.rf_waddr !== 5'd4 || bus.pipe_stall !== 1'b0 || bus.rs_pending !== 1'b1)
        begin errors++; $display("FAIL starve_wb_%0d: got addr=%0d stall=%0b pend=%0b expected 4 0 1", i, bus.rf_waddr, bus.pipe_stall, bus.rs_pending); end
      advance();
    end
    settle();
    checks++; if (bus.pipe_stall !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'hAAAA || bus.mdu_ready !== 1'b1)
      begin errors++; $display("FAIL starve_force: got stall=%0b addr=%0d data=%0h ready=%0b expected 1 10 aaaa 1", bus.pipe_stall, bus.rf_waddr, bus.rf_wdata, bus.mdu_ready); end
    advance();
    settle();
    checks++; if (bus.pipe_stall !== 1'b0 || bus.rf_waddr !== 5'd4 || bus.rs_pending !== 1'b0)
      begin errors++; $display("FAIL starve_resume: got stall=%0b addr=%0d pend=%0b expected 0 4 0", bus.pipe_stall, bus.rf_waddr, bus.rs_pending); end
    advance();
  endtask

  task automatic test_waw_kill();
    drive(1, 1, 32'h1, 1, 12, 32'h5555, 12, 0);
    settle();
    advance();
    drive(1, 12, 32'h7, 0, 0, 0, 12, 0);
    settle();
    checks++; if (bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'h7 || bus.mdu_ready !== 1'b1)
      begin errors++; $display("FAIL waw_write: got addr=%0d data=%0h ready=%0b expected 12 7 1", bus.rf_waddr, bus.rf_wdata, bus.mdu_ready); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 12, 0);
    settle();
    checks++; if (bus.rs_pending !== 1'b0 || bus.rf_we !== 1'b0)
      begin errors++; $display("FAIL waw_cleared: got pend=%0b we=%0b expected 0 0", bus.rs_pending, bus.rf_we); end
    advance();
    settle();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL waw_no_late_write: got we=%0b expected 0", bus.rf_we); end
    advance();
  endtask

  task automatic test_reg0();
    drive(0, 0, 0, 1, 0, 32'h9999, 0, 0);
    settle();
    checks++; if (bus.mdu_ready !== 1'b1 || bus.rf_we !== 1'b0)
      begin errors++; $display("FAIL reg0_mdu: got ready=%0b we=%0b expected 1 0", bus.mdu_ready, bus.rf_we); end
    advance();
    drive(1, 0, 32'h5, 0, 0, 0, 0, 0);
    settle();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reg0_wb: got we=%0b expected 0", bus.rf_we); end
    advance();
    drive(1, 2, 32'h22, 1, 7, 32'h77, 0, 0);
    settle();
    advance();
    drive(1, 0, 32'h5, 0, 0, 0, 0, 0);
    settle();
    checks++; if (bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h77)
      begin errors++; $display("FAIL reg0_wb_drains: got addr=%0d data=%0h expected 7 77", bus.rf_waddr, bus.rf_wdata); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1, 2, 32'h2, 1, 13, 32'hD, 0, 0);
    settle();
    advance();
    drive(1, 2, 32'h2, 0, 0, 0, 13, 13);
    settle();
    checks++; if (bus.rs_pending !== 1'b1 || bus.mdu_ready !== 1'b0)
      begin errors++; $display("FAIL midreset_before: got pend=%0b ready=%0b expected 1 0", bus.rs_pending, bus.mdu_ready); end
    reset = 1;
    #1;
    checks++; if (bus.rs_pending !== 1'b0 || bus.rt_pending !== 1'b0 || bus.mdu_ready !== 1'b1)
      begin errors++; $display("FAIL midreset_held: got rs=%0b rt=%0b ready=%0b expected 0 0 1", bus.rs_pending, bus.rt_pending, bus.mdu_ready); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    drive(1, 4, 32'h4, 1, 11, 32'hB, 0, 0);
    settle();
    advance();
    drive(1, 4, 32'h4, 0, 0, 0, 0, 0);
    repeat (LIMIT) begin settle(); advance(); end
    settle();
    checks++; if (bus.pipe_stall !== 1'b1) begin errors++; $display("FAIL midreset_force: got stall=%0b expected 1", bus.pipe_stall); end
    reset = 1;
    #1;
    checks++; if (bus.pipe_stall !== 1'b0 || bus.rf_waddr !== 5'd4)
      begin errors++; $display("FAIL midreset_stall_drop: got stall=%0b addr=%0d expected 0 4", bus.pipe_stall, bus.rf_waddr); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int wb_pct;
      wb_pct = ((i % 120) < 60) ? 95 : 40;
      drive(($urandom_range(0, 99) < wb_pct), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      settle();
      checks++;
      if (bus.rf_we !== exp_we || bus.rf_waddr !== exp_addr || bus.rf_wdata !== exp_data)
        begin errors++; $display("FAIL rand_write cyc %0d: got we=%0b addr=%0d data=%0h expected we=%0b addr=%0d data=%0h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_we, exp_addr, exp_data); end
      checks++;
      if (bus.mdu_ready !== exp_ready || bus.pipe_stall !== exp_stall)
        begin errors++; $display("FAIL rand_ctrl cyc %0d: got ready=%0b stall=%0b expected ready=%0b stall=%0b", i, bus.mdu_ready, bus.pipe_stall, exp_ready, exp_stall); end
      checks++;
      if (bus.rs_pending !== exp_rsp || bus.rt_pending !== exp_rtp)
        begin errors++; $display("FAIL rand_pending cyc %0d: got rs=%0b rt=%0b expected rs=%0b rt=%0b", i, bus.rs_pending, bus.rt_pending, exp_rsp, exp_rtp); end
      advance();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_wb_basic();
    test_write_through();
    test_buffer_drain();
    test_starvation();
    test_waw_kill();
    test_reg0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
